// File: rtl/vga_plot_fifo.sv
// Purpose: clip drawing-engine pixel plots to the screen and buffer on-screen pixels for the VGA adapter.
// Latency: a pixel accepted at edge N is presented on out_* with out_plot=1 after edge N, and can be popped at edge N+1.
// Backpressure: in_ready is low only when the FIFO is full; out_ready low holds the head entry stable.
//
// Ports:
//   clk, rst_n                    single clock; asynchronous active-low reset
//   in_x/in_y/in_colour/in_plot   upstream pixel and valid; in_ready is the upstream ready
//   out_x/out_y/out_colour        head-of-FIFO pixel; out_plot is valid, out_ready is the downstream accept
//   clear_stats                   synchronous clear of both statistics counters
//   written_count, clipped_count  saturating counts of popped pixels and of clipped pixels

// Generic synchronous FIFO: one write port and one read port, registered occupancy count.
// Latency: written data is visible at the read port one edge after the write.
// Backpressure: wr_rdy depends only on the registered count, so a read never opens a write in the same cycle.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_vld,
    input  logic [WIDTH-1:0]           wr_dat,
    output logic                       wr_rdy,
    output logic                       rd_vld,
    output logic [WIDTH-1:0]           rd_dat,
    input  logic                       rd_rdy,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign wr_rdy = (count != FULL_C);
    assign rd_vld = (count != '0);
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_vld && rd_rdy;

    // The head slot is always presented, so the storage is reset to give
    // all-zero read data straight out of reset.
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module vga_plot_fifo #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_x,
    input  logic [6:0]  in_y,
    input  logic [2:0]  in_colour,
    input  logic        in_plot,
    output logic        in_ready,
    output logic [7:0]  out_x,
    output logic [6:0]  out_y,
    output logic [2:0]  out_colour,
    output logic        out_plot,
    input  logic        out_ready,
    input  logic        clear_stats,
    output logic [15:0] written_count,
    output logic [15:0] clipped_count
);
    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pix_t;

    localparam logic [7:0] W_LIM = 8'(SCREEN_W);
    localparam logic [6:0] H_LIM = 7'(SCREEN_H);

    pix_t                   in_dat;
    pix_t                   out_dat;
    logic                   in_bounds;
    logic                   accept;
    logic                   pop;
    logic [$clog2(DEPTH):0] count;

    assign in_dat    = '{x: in_x, y: in_y, colour: in_colour};
    assign in_bounds = (in_x < W_LIM) && (in_y < H_LIM);

    // An off-screen pixel still completes the upstream handshake; it simply
    // never reaches the FIFO write port.
    assign accept = in_plot && in_ready;
    assign pop    = out_plot && out_ready;

    fifo #(
        .WIDTH ($bits(pix_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (in_plot && in_bounds),
        .wr_dat (in_dat),
        .wr_rdy (in_ready),
        .rd_vld (out_plot),
        .rd_dat (out_dat),
        .rd_rdy (out_ready),
        .count  (count)
    );

    assign out_x      = out_dat.x;
    assign out_y      = out_dat.y;
    assign out_colour = out_dat.colour;

    // Statistics: clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_count <= '0;
            clipped_count <= '0;
        end else if (clear_stats) begin
            written_count <= '0;
            clipped_count <= '0;
        end else begin
            if (pop && (written_count != 16'hFFFF)) begin
                written_count <= written_count + 16'd1;
            end
            if (accept && !in_bounds && (clipped_count != 16'hFFFF)) begin
                clipped_count <= clipped_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_vga_plot_fifo.sv
// Bench for vga_plot_fifo: a cycle model with an expected-pixel queue checks every
// cycle, while directed sequences and a clipping vector table cover the corner cases.
module tb_vga_plot_fifo;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_x = '0;
    logic [6:0]  in_y = '0;
    logic [2:0]  in_colour = '0;
    logic        in_plot = 1'b0;
    logic        in_ready;
    logic [7:0]  out_x;
    logic [6:0]  out_y;
    logic [2:0]  out_colour;
    logic        out_plot;
    logic        out_ready = 1'b0;
    logic        clear_stats = 1'b0;
    logic [15:0] written_count;
    logic [15:0] clipped_count;

    vga_plot_fifo #(.DEPTH(DEPTH), .SCREEN_W(160), .SCREEN_H(120)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_x          (in_x),
        .in_y          (in_y),
        .in_colour     (in_colour),
        .in_plot       (in_plot),
        .in_ready      (in_ready),
        .out_x         (out_x),
        .out_y         (out_y),
        .out_colour    (out_colour),
        .out_plot      (out_plot),
        .out_ready     (out_ready),
        .clear_stats   (clear_stats),
        .written_count (written_count),
        .clipped_count (clipped_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        bit         stored;
    } vec_t;

    pix_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   m_written = 0;
    int   m_clipped = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle model: compare first, then predict the handshakes of the coming edge.
    always @(negedge clk) begin
        bit do_pop;
        bit do_push;
        if (!rst_n) begin
            q.delete();
            m_written = 0;
            m_clipped = 0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            chk("out_plot", 32'(out_plot), 32'(q.size() > 0));
            chk("count", 32'(u_dut.u_fifo.count), 32'(q.size()));
            chk("written_count", 32'(written_count), 32'(m_written));
            chk("clipped_count", 32'(clipped_count), 32'(m_clipped));
            if (q.size() > 0) begin
                chk("head_pixel", 32'({out_x, out_y, out_colour}), 32'(q[0]));
            end
            do_pop  = (q.size() > 0) && out_ready;
            do_push = in_plot && (q.size() < DEPTH);
            if (do_pop) begin
                void'(q.pop_front());
                if (m_written < 65535) m_written++;
            end
            if (do_push) begin
                if (in_x < 8'd160 && in_y < 7'd120) begin
                    q.push_back({in_x, in_y, in_colour});
                end else if (m_clipped < 65535) begin
                    m_clipped++;
                end
            end
            if (clear_stats) begin
                m_written = 0;
                m_clipped = 0;
            end
        end
    end

    // Present one pixel and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        bit acc = 1'b0;
        int t = 0;
        in_x = x;
        in_y = y;
        in_colour = c;
        in_plot = 1'b1;
        while (!acc && t < 500) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
        in_plot = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() > 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   exp_clip;
        int   exp_stored;

        vecs[0] = '{x: 8'd159, y: 7'd119, c: 3'd1, stored: 1'b1};
        vecs[1] = '{x: 8'd160, y: 7'd0,   c: 3'd2, stored: 1'b0};
        vecs[2] = '{x: 8'd0,   y: 7'd120, c: 3'd3, stored: 1'b0};
        vecs[3] = '{x: 8'd255, y: 7'd127, c: 3'd4, stored: 1'b0};
        vecs[4] = '{x: 8'd0,   y: 7'd0,   c: 3'd5, stored: 1'b1};
        vecs[5] = '{x: 8'd80,  y: 7'd60,  c: 3'd6, stored: 1'b1};
        vecs[6] = '{x: 8'd159, y: 7'd120, c: 3'd7, stored: 1'b0};
        vecs[7] = '{x: 8'd161, y: 7'd119, c: 3'd0, stored: 1'b0};

        // Reset values before any clock edge.
        #1;
        chk("rst_out_plot", 32'(out_plot), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'({out_x, out_y, out_colour}), 32'd0);
        chk("rst_written", 32'(written_count), 32'd0);
        chk("rst_clipped", 32'(clipped_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Five in-bounds pixels straight through.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(8'(10 + i), 7'd20, 3'b010);
            if (i == 0) begin
                chk("latency_out_plot", 32'(out_plot), 32'd1);
                chk("latency_out_x", 32'(out_x), 32'd10);
            end
        end
        drain();
        chk("t1_written", 32'(written_count), 32'd5);
        chk("t1_clipped", 32'(clipped_count), 32'd0);

        // Fill to full, hold the ninth, then release.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(8'(30 + i), 7'(i), 3'(i));
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_x = 8'd50;
        in_y = 7'd9;
        in_colour = 3'd7;
        in_plot = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("held_in_ready", 32'(in_ready), 32'd0);
            chk("held_head_x", 32'(out_x), 32'd30);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_pop", 32'(in_ready), 32'd1);
        send(8'd50, 7'd9, 3'd7);
        drain();
        chk("t2_written", 32'(written_count), 32'd14);

        // Clear, then the clipping vector table.
        clear_stats = 1'b1;
        @(posedge clk);
        #1;
        clear_stats = 1'b0;
        chk("clear_written", 32'(written_count), 32'd0);
        chk("clear_clipped", 32'(clipped_count), 32'd0);
        exp_clip = 0;
        exp_stored = 0;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].x, vecs[i].y, vecs[i].c);
            if (vecs[i].stored) exp_stored++;
            else exp_clip++;
        end
        drain();
        chk("table_clipped", 32'(clipped_count), 32'(exp_clip));
        chk("table_written", 32'(written_count), 32'(exp_stored));

        // Steady push+pop at count 3 across two pointer wraps.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(8'(100 + i), 7'd1, 3'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(8'(i), 7'(i + 40), 3'(i));
            chk("steady_count", 32'(u_dut.u_fifo.count), 32'd3);
        end
        drain();
        chk("t4_written", 32'(written_count), 32'(exp_stored + 23));

        // Asynchronous reset with entries buffered.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(60 + i), 7'd5, 3'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_plot", 32'(out_plot), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_written", 32'(written_count), 32'd0);
        chk("arst_clipped", 32'(clipped_count), 32'd0);
        chk("arst_out_data", 32'({out_x, out_y, out_colour}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(8'd77, 7'd33, 3'd5);
        chk("post_rst_first_x", 32'(out_x), 32'd77);
        drain();
        chk("post_rst_written", 32'(written_count), 32'd1);

        // Clear in the same cycle as a pop.
        out_ready = 1'b0;
        send(8'd1, 7'd1, 3'd1);
        clear_stats = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clear_stats = 1'b0;
        chk("clear_vs_pop", 32'(written_count), 32'd0);
        chk("clear_vs_pop_plot", 32'(out_plot), 32'd0);

        // Saturation: more than 65535 pops at one per cycle.
        in_plot = 1'b1;
        for (int i = 0; i < 65600; i++) begin
            in_x = 8'(i % 160);
            in_y = 7'(i % 120);
            in_colour = 3'(i);
            @(posedge clk);
            #1;
        end
        in_plot = 1'b0;
        drain();
        chk("saturated_written", 32'(written_count), 32'd65535);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
